// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine: FSM states, algorithm
// selection and the width helper for the Stein shift count.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

  localparam int GCD_SUB = 0;
  localparam int GCD_BIN = 1;

  // Never returns less than 1 so the shift-count register always exists.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/gcd_step.sv
// Combinational next-state of one CALC iteration for either the subtractive
// Euclid or the binary Stein algorithm.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODE  = GCD_SUB,
  parameter int K_W   = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [K_W-1:0]   k,
  output logic [WIDTH-1:0] x_nxt,
  output logic [WIDTH-1:0] y_nxt,
  output logic [K_W-1:0]   k_nxt,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // In subtractive mode k stays zero, so the final shift is a no-op.
  always_comb begin
    x_nxt  = x;
    y_nxt  = y;
    k_nxt  = k;
    done   = 1'b0;
    result = x << k;
    if (x == y) begin
      done = 1'b1;
    end else if (MODE == GCD_BIN) begin
      if (!x[0] && !y[0]) begin
        x_nxt = x >> 1;
        y_nxt = y >> 1;
        k_nxt = k + 1'b1;
      end else if (!x[0]) begin
        x_nxt = x >> 1;
      end else if (!y[0]) begin
        y_nxt = y >> 1;
      end else if (x > y) begin
        x_nxt = x - y;
      end else begin
        y_nxt = y - x;
      end
    end else begin
      if (x > y) x_nxt = x - y;
      else       y_nxt = y - x;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine: valid/ready operand intake, iterative CALC loop and a held
// result with a saturating per-job cycle count.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// CALC  | one algorithm iteration per cycle
// DONE  | result presented, waiting for out_ready
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODE  = GCD_SUB,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd,
  output logic [CNT_W-1:0] cycles
);

  localparam int K_W = clog2(WIDTH);

  gcd_state_t       state, state_nxt;
  logic [WIDTH-1:0] x_q, y_q, gcd_q;
  logic [K_W-1:0]   k_q;
  logic [CNT_W-1:0] cycles_q;

  logic [WIDTH-1:0] x_nxt, y_nxt, step_result;
  logic [K_W-1:0]   k_nxt;
  logic             step_done;
  logic             accept, zero_op;

  assign accept  = in_valid && (state == IDLE);
  assign zero_op = (in_x == '0) || (in_y == '0);

  gcd_step #(
    .WIDTH (WIDTH),
    .MODE  (MODE),
    .K_W   (K_W)
  ) u_step (
    .x      (x_q),
    .y      (y_q),
    .k      (k_q),
    .x_nxt  (x_nxt),
    .y_nxt  (y_nxt),
    .k_nxt  (k_nxt),
    .done   (step_done),
    .result (step_result)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = zero_op ? DONE : CALC;
      CALC: if (step_done) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      gcd_q    <= '0;
      cycles_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          x_q      <= in_x;
          y_q      <= in_y;
          k_q      <= '0;
          cycles_q <= '0;
          if (zero_op) gcd_q <= in_x | in_y;
        end
        CALC: begin
          x_q <= x_nxt;
          y_q <= y_nxt;
          k_q <= k_nxt;
          if (cycles_q != '1) cycles_q <= cycles_q + 1'b1;
          if (step_done) gcd_q <= step_result;
        end
        default: ;
      endcase
    end
  end

  assign gcd    = gcd_q;
  assign cycles = cycles_q;

endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Parametrised, self-contained GCD engine: control FSM plus datapath in one block.
- Successor to the fixed-width Euclid control unit; adds operand width parameter, selectable subtractive/binary (Stein) algorithm, and valid/ready handshakes on input and output.
- Adds zero-operand handling and a per-job cycle count.
- Sits between an operand source (host/stream) and a result consumer.

Parameters:
WIDTH, 16, operand and result width in bits (>=2).
MODE, 0, 0 = subtractive Euclid; 1 = binary Stein algorithm.
CNT_W, 16, width of the cycle counter output; counter saturates at all-ones.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  engine can accept operands; high only in IDLE
in_x  input  WIDTH  operand X
in_y  input  WIDTH  operand Y
out_valid  output  1  result valid; high only in DONE
out_ready  input  1  consumer accepts result
gcd  output  WIDTH  result; held stable while out_valid=1
cycles  output  CNT_W  number of CALC cycles spent on this job; stable with gcd

Behaviour:
- Reset (sync, at clk edge with reset=1): state=IDLE, in_ready=1, out_valid=0, gcd=0, cycles=0, internal x/y/k=0. Reset has priority over everything, including mid-CALC and DONE.
- States: IDLE, CALC, DONE.
- IDLE: on in_valid && in_ready, latch x=in_x, y=in_y, k=0, cycles=0.
  - If in_x==0 or in_y==0: gcd = in_x | in_y (gcd(0,0)=0); go to DONE with cycles=0.
  - Else go to CALC.
- CALC, MODE=0: evaluated once per cycle.
  - If x==y: gcd=x; go to DONE.
  - Else if x>y: x=x-y.
  - Else: y=y-x.
- CALC, MODE=1: evaluated once per cycle, in priority order.
  - If x==y: gcd = x<<k; go to DONE.
  - Else if x and y both even: both shift right by 1, k=k+1.
  - Else if x even: x>>1.
  - Else if y even: y>>1.
  - Else: the larger operand is replaced by (larger - smaller).
  - k width is clog2(WIDTH). Result never exceeds the original operands, so x<<k fits WIDTH with no overflow.
- cycles increments by 1 on every CALC cycle, including the final x==y cycle. It saturates at 2^CNT_W-1 and never wraps.
- DONE: out_valid=1; gcd and cycles held.
  - On out_ready=1: go to IDLE; out_valid falls the next cycle.
  - in_ready=0 in DONE, so an in_valid coinciding with out_ready is not accepted that cycle. It is accepted no earlier than the following cycle (IDLE).
- Latency:
  - Nonzero operands: out_valid rises the cycle after the final CALC cycle.
  - Zero operand: out_valid rises one cycle after accept.
- in_x/in_y are ignored outside the accept cycle.
- Subtractors and comparators are WIDTH bits wide, unsigned.

Decomposition:
- Package gcd_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - MODE constants GCD_SUB=0, GCD_BIN=1;
  - function clog2 for the k width.
- One natural sub-module: gcd_step, the combinational next-(x,y,k,done) logic for one CALC iteration, selected by MODE. The FSM, registers and handshake stay in gcd_engine.

Test Plan:
1. MODE=0, WIDTH=16, (48,18), out_ready=1 -> sequence 30/18, 12/18, 12/6, 6/6; gcd=6, cycles=5; in_ready low from accept until return to IDLE.
2. MODE=1, (48,18) -> k=1 after first step, then 12/9, 6/9, 3/9, 3/6, 3/3; gcd=6, cycles=7.
3. Zero operands: (0,25) -> gcd=25, cycles=0, out_valid one cycle after accept; (0,0) -> gcd=0; (25,0) -> 25.
4. Backpressure: (35,14) with out_ready=0 for 3 cycles after out_valid -> gcd=7 and cycles held stable, in_ready=0 throughout; release -> IDLE next cycle.
5. Reset mid-operation: assert reset during CALC of (65535,1) -> next cycle IDLE, in_ready=1, out_valid=0, gcd=0, cycles=0; a new job (12,8) then returns 4.
6. Saturation/back-to-back: CNT_W=4, MODE=0, (65535,1) -> gcd=1, cycles=15 (saturated). Then in_valid held high across DONE with out_ready=1 -> second job accepted only in the following IDLE cycle.
